// File: rtl/round_sequencer.sv
// round_sequencer: 1-2-3 wooden man round FSM (green/turn/grace/red loop, kill/win/timeout judge).
// Ports: clk, rst (sync high), start, p1/p2_move, p1/p2_pos in; allow, en, turn, music_sel, p1/p2_kill, now_state out.
module round_sequencer #(
   parameter int TICK_DIV    = 1_000_000,
   parameter int GREEN_MIN   = 150,
   parameter int TURN_TICKS  = 60,
   parameter int GRACE_TICKS = 30,
   parameter int RED_TICKS   = 300,
   parameter int GOAL_POS    = 20,
   parameter int ROUND_LIMIT = 6000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       p1_move,
   input  logic       p2_move,
   input  logic [4:0] p1_pos,
   input  logic [4:0] p2_pos,
   output logic       allow,
   output logic       en,
   output logic       turn,
   output logic [1:0] music_sel,
   output logic       p1_kill,
   output logic       p2_kill,
   output logic [3:0] now_state
);

   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);
   localparam logic [15:0]   L_GMIN   = 16'(GREEN_MIN);
   localparam logic [15:0]   L_TURN   = 16'(TURN_TICKS);
   localparam logic [15:0]   L_GRACE  = 16'(GRACE_TICKS);
   localparam logic [15:0]   L_RED    = 16'(RED_TICKS);
   localparam logic [15:0]   RLIM     = 16'(ROUND_LIMIT);
   localparam logic [4:0]    GOAL     = 5'(GOAL_POS);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_GREEN    = 4'd1,
      S_TURN_IN  = 4'd2,
      S_GRACE    = 4'd3,
      S_RED      = 4'd4,
      S_TURN_OUT = 4'd5,
      S_P1_WIN   = 4'd6,
      S_P2_WIN   = 4'd7,
      S_DRAW     = 4'd8,
      S_ALL_DEAD = 4'd9,
      S_TIMEOUT  = 4'd10
   } state_t;

   state_t        r_state;
   logic [15:0]   r_lfsr;
   logic [15:0]   r_phase;
   logic [15:0]   r_round;
   logic [DW-1:0] r_div;
   logic          r_k1;
   logic          r_k2;
   logic          r_f1;
   logic          r_f2;
   logic          r_allow;
   logic          r_en;
   logic          r_turn;
   logic [1:0]    r_music;

   state_t        w_next;
   logic          w_active;
   logic          w_tick;
   logic          w_fb;
   logic [15:0]   w_green;
   logic [15:0]   w_len;
   logic          w_load;
   logic          w_fin1;
   logic          w_fin2;
   logic          w_f1a;
   logic          w_f2a;
   logic          w_draw;
   logic          w_p1w;
   logic          w_p2w;
   logic          w_dead;
   logic          w_tmo;
   logic          w_to_tmo;
   logic          w_k1_set;
   logic          w_k2_set;
   logic          w_allow;
   logic          w_en;
   logic          w_turn;
   logic [1:0]    w_music;

   assign w_active = (r_state >= S_GREEN) && (r_state <= S_TURN_OUT);
   assign w_tick   = w_active && (r_div == DIV_LAST);
   assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_green  = L_GMIN + {12'd0, r_lfsr[3:0]};

   // "finished now" uses the live position; r_f* remembers who got there first
   assign w_fin1 = !r_k1 && (p1_pos >= GOAL);
   assign w_fin2 = !r_k2 && (p2_pos >= GOAL);
   assign w_f1a  = r_f1 || w_fin1;
   assign w_f2a  = r_f2 || w_fin2;

   assign w_draw = w_fin1 && w_fin2 && !r_f1 && !r_f2;
   assign w_p1w  = w_f1a && (r_k2 || (w_f2a && r_f1));
   assign w_p2w  = w_f2a && (r_k1 || (w_f1a && r_f2));
   assign w_dead = r_k1 && r_k2;
   assign w_tmo  = (r_round >= RLIM) ||
                   (w_tick && (r_round == RLIM - 16'd1));

   always_comb begin
      w_next   = r_state;
      w_load   = 1'b0;
      w_len    = w_green;
      w_to_tmo = 1'b0;
      if (!w_active) begin
         if (start) begin
            w_next = S_GREEN;
            w_load = 1'b1;
         end
      end else if (w_draw) begin
         w_next = S_DRAW;
      end else if (w_p1w) begin
         w_next = S_P1_WIN;
      end else if (w_p2w) begin
         w_next = S_P2_WIN;
      end else if (w_dead) begin
         w_next = S_ALL_DEAD;
      end else if (w_tmo) begin
         w_next   = S_TIMEOUT;
         w_to_tmo = 1'b1;
      end else if (w_tick && (r_phase == 16'd1)) begin
         w_load = 1'b1;
         case (r_state)
            S_GREEN: begin
               w_next = S_TURN_IN;
               w_len  = L_TURN;
            end
            S_TURN_IN: begin
               w_next = S_GRACE;
               w_len  = L_GRACE;
            end
            S_GRACE: begin
               w_next = S_RED;
               w_len  = L_RED;
            end
            S_RED: begin
               w_next = S_TURN_OUT;
               w_len  = L_TURN;
            end
            default: begin
               w_next = S_GREEN;
               w_len  = w_green;
            end
         endcase
      end
   end

   // moves are judged only while the doll watches; timeout kills the unfinished
   assign w_k1_set = ((r_state == S_RED) && p1_move && !r_k1 && !w_f1a) ||
                     (w_to_tmo && !w_f1a);
   assign w_k2_set = ((r_state == S_RED) && p2_move && !r_k2 && !w_f2a) ||
                     (w_to_tmo && !w_f2a);

   // outputs are decoded from the next state so they register with it
   always_comb begin
      w_allow = 1'b0;
      w_en    = 1'b0;
      w_turn  = 1'b0;
      w_music = 2'd0;
      case (w_next)
         S_GREEN: begin
            w_allow = 1'b1;
            w_en    = 1'b1;
            w_music = 2'd1;
         end
         S_TURN_IN, S_GRACE: begin
            w_allow = 1'b1;
            w_en    = 1'b1;
            w_turn  = 1'b1;
         end
         S_RED: begin
            w_en   = 1'b1;
            w_turn = 1'b1;
         end
         S_TURN_OUT: w_en = 1'b1;
         S_P1_WIN, S_P2_WIN, S_DRAW: w_music = 2'd2;
         S_ALL_DEAD, S_TIMEOUT: w_music = 2'd3;
         default: w_music = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_lfsr  <= 16'hACE1;
         r_phase <= '0;
         r_round <= '0;
         r_div   <= '0;
         r_k1    <= 1'b0;
         r_k2    <= 1'b0;
         r_f1    <= 1'b0;
         r_f2    <= 1'b0;
         r_allow <= 1'b0;
         r_en    <= 1'b0;
         r_turn  <= 1'b0;
         r_music <= 2'd0;
      end else begin
         r_lfsr  <= {r_lfsr[14:0], w_fb};
         r_state <= w_next;
         r_allow <= w_allow;
         r_en    <= w_en;
         r_turn  <= w_turn;
         r_music <= w_music;
         if (w_load) begin
            r_phase <= w_len;
         end else if (w_tick) begin
            r_phase <= r_phase - 16'd1;
         end
         if (!w_active) begin
            if (start) begin
               r_div   <= '0;
               r_round <= '0;
               r_k1    <= 1'b0;
               r_k2    <= 1'b0;
               r_f1    <= 1'b0;
               r_f2    <= 1'b0;
            end
         end else begin
            r_div <= w_tick ? '0 : r_div + DIV_ONE;
            if (w_tick && (r_round != RLIM)) begin
               r_round <= r_round + 16'd1;
            end
            if (w_fin1) r_f1 <= 1'b1;
            if (w_fin2) r_f2 <= 1'b1;
            if (w_k1_set) r_k1 <= 1'b1;
            if (w_k2_set) r_k2 <= 1'b1;
         end
      end
   end

   assign allow     = r_allow;
   assign en        = r_en;
   assign turn      = r_turn;
   assign music_sel = r_music;
   assign p1_kill   = r_k1;
   assign p2_kill   = r_k2;
   assign now_state = r_state;

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Game-round controller for the "1-2-3 wooden man" board. It sequences each round through a green phase (music on, doll facing away), the motor turn, a grace window and a red watch phase, then turns back. It drives `allow`, `turn`, `en` and the music select to the player, motor and audio blocks. It also judges kills, wins and timeouts from the player position and move strobes, and exports its state code for the seven-segment display.

## Interface
- `TICK_DIV`, 1_000_000: clk cycles per game tick (10 ms at 100 MHz).
- `GREEN_MIN`, 150: minimum green-phase length, ticks.
- `TURN_TICKS`, 60: motor travel time per turn, ticks.
- `GRACE_TICKS`, 30: reaction window after the doll faces players, ticks.
- `RED_TICKS`, 300: red watch length, ticks.
- `GOAL_POS`, 20: position at which a player finishes (5-bit compare).
- `ROUND_LIMIT`, 6000: global round time limit, ticks.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a round from IDLE or from any end state.
- `p1_move`, `p2_move` in 1: one-cycle move strobes from the keyboard decoder.
- `p1_pos`, `p2_pos` in 5: current player positions.
- `allow` out 1: players may advance.
- `en` out 1: round active; player block holds positions at 0 while low.
- `turn` out 1: motor target level; 1 means the doll faces the players.
- `music_sel` out 2: 0 silent, 1 green song, 2 win jingle, 3 lose tone.
- `p1_kill`, `p2_kill` out 1: sticky per-round death flags.
- `now_state` out 4: state code below.

## Operation
- States and codes: IDLE 0, GREEN 1, TURN_IN 2, GRACE 3, RED 4, TURN_OUT 5, P1_WIN 6, P2_WIN 7, DRAW 8, ALL_DEAD 9, TIMEOUT 10. Codes 11–15 are unused and decode to IDLE.
- Phase loop: GREEN → TURN_IN → GRACE → RED → TURN_OUT → GREEN, until an end condition occurs.
- Phase lengths:
  - GREEN lasts `GREEN_MIN + lfsr[3:0]` ticks.
  - TURN_IN and TURN_OUT last `TURN_TICKS`.
  - GRACE lasts `GRACE_TICKS`.
  - RED lasts `RED_TICKS`.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11. Seed 16'hACE1 on reset. Advances every clk. Sampled on the cycle the phase counter loads.
- Outputs by state:
  - `allow` = 1 in GREEN, TURN_IN and GRACE; 0 elsewhere.
  - `turn` = 1 in TURN_IN, GRACE and RED.
  - `en` = 1 in states 1–5.
  - `music_sel` = 1 in GREEN, 2 in P1_WIN, P2_WIN and DRAW, 3 in ALL_DEAD and TIMEOUT, 0 elsewhere.
- Kill rule: in RED, a move strobe from a player that is neither killed nor finished sets that player's kill flag. Moves are never judged in any other state.
- A player is finished when their kill flag is 0 and `pos >= GOAL_POS`.
- End conditions are evaluated every cycle in states 1–5 and take priority over phase transitions, in this order:
  1. Both players finish on the same cycle → DRAW.
  2. P1 finished first, or P1 finished and P2 is killed → P1_WIN.
  3. Mirror of rule 2 for P2 → P2_WIN.
  4. Both players killed → ALL_DEAD.
  5. Round tick count reaches `ROUND_LIMIT` → TIMEOUT; the kill flag of every unfinished player is set.
- The round continues while one player is finished and the other is alive. The first finisher wins when the other player dies or times out.
- End states hold until `start` or `rst`.
- `start` in IDLE or any end state clears the kill flags, finished flags, round counter and tick divider, and enters GREEN. `start` in states 1–5 is ignored.

## Timing
- Reset values:
  - state IDLE; `allow`, `en`, `turn`, `p1_kill`, `p2_kill` = 0; `music_sel` = 0; `now_state` = 0.
  - Tick divider, phase counter and round counter = 0; LFSR = 16'hACE1.
- All outputs are registered.
- `start` sampled at cycle n → `now_state` = 1, `en` = 1, `allow` = 1 at n+1.
- Tick: the divider counts 0..`TICK_DIV`-1 and emits a one-cycle tick at wrap. The divider restarts at 0 on round start.
- Phase counter:
  - Loaded with the phase length on the entry cycle; decremented on each tick.
  - On a tick with counter == 1, the next state is registered, so a phase lasts exactly its length in ticks.
- A move strobe in RED at cycle n → kill flag high at n+1.
  - A strobe on the last RED cycle still kills.
  - A strobe on the first TURN_OUT cycle does not kill.
- End-condition detection at cycle n → end state at n+1. When both are due on the same cycle, the end state overrides the phase transition.
- The round counter saturates at `ROUND_LIMIT`.
- Reset mid-round forces IDLE on the next cycle regardless of state.

## Test plan
Sim parameters: `TICK_DIV`=4, `GREEN_MIN`=8, `TURN_TICKS`=3, `GRACE_TICKS`=2, `RED_TICKS`=10, `ROUND_LIMIT`=200, `GOAL_POS`=20.

- Phase cadence: reset, pulse `start`, apply no moves.
  - GREEN length = (8 + `lfsr[3:0]` at entry)·4 cycles, then TURN_IN for 12 cycles, GRACE 8, RED 40, TURN_OUT 12, then GREEN again.
  - `allow` and `turn` match the table in Operation on every cycle.
- Kill judging:
  - `p1_move` in GRACE → no kill.
  - `p1_move` in RED → `p1_kill` = 1 next cycle, `now_state` stays 4.
  - `p2_move` in the same RED phase → ALL_DEAD (9), `music_sel` = 3.
- Win: `p1_pos` = 20 in GREEN with P1 alive; P2 killed one RED phase later → P1_WIN (6), `music_sel` = 2, `en` = 0.
- Draw: `p1_pos` and `p2_pos` both reach 20 on the same cycle → DRAW (8).
- Timeout: both players idle → TIMEOUT (10) after 800 cycles; both kill flags = 1. Then `start` → GREEN, kill flags = 0.
- Reset mid-RED: assert `rst` for 1 cycle → next cycle all outputs are at their reset values and LFSR = 16'hACE1.
